uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/serializer bundle for uart_tx_arbiter: slave = arbiter side, master = sources plus uart_tx.
interface uart_tx_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
);
   logic [NREQ-1:0]       i_req;
   logic [NREQ*WIDTH-1:0] i_data;
   logic [NREQ-1:0]       o_ack;
   logic [GW-1:0]         o_grant;
   logic                  o_busy;
   logic                  o_tx_stb;
   logic                  o_tx_wr;
   logic [WIDTH-1:0]      o_tx_data;
   logic                  i_tx_busy;

   modport slave (
      input  i_req, i_data, i_tx_busy,
      output o_ack, o_grant, o_busy, o_tx_stb, o_tx_wr, o_tx_data
   );

   modport master (
      output i_req, i_data, i_tx_busy,
      input  o_ack, o_grant, o_busy, o_tx_stb, o_tx_wr, o_tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NREQ byte sources: baud strobe, round-robin arbitration, load and ack.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest requester index wins, no RR pointer).
module uart_tx_arbiter #(
   parameter int WIDTH         = 8,
   parameter int NREQ          = 4,
   parameter int CLKS_PER_BAUD = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   uart_tx_arbiter_if.slave bus
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic             r_stb;
   logic [NREQ-1:0]  r_ack;
   logic [NREQ-1:0]  w_ack_nxt;
   logic [GW-1:0]    r_grant;
   logic [GW-1:0]    w_grant_nxt;
   logic             r_wr;
   logic             w_wr_nxt;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_data_nxt;
   logic             r_first;
   logic             w_first_nxt;
   logic             r_busy;
   logic             w_found;
   logic [GW-1:0]    w_win;
`ifndef UART_ARB_FIXED_PRIO_EN
   logic [GW-1:0]    r_ptr;
   logic [GW-1:0]    w_ptr_nxt;
   logic             w_hit;
   int               w_idx;
`endif

   // Free-running baud divider; strobe registered off the wrap count so the first pulse lands CLKS_PER_BAUD cycles after reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_stb <= 1'b0;
      end else begin
         r_stb <= (r_cnt == CW'(CLKS_PER_BAUD - 1));
         if (r_cnt == CW'(CLKS_PER_BAUD - 1)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Winner selection among pending requests
   always_comb begin
      w_found = |bus.i_req;
      w_win   = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_win = bus.i_req[k] ? GW'(k) : w_win;
      end
`else
      w_hit = 1'b0;
      w_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NREQ;
         w_win = (bus.i_req[w_idx] && !w_hit) ? GW'(w_idx) : w_win;
         w_hit = w_hit | bus.i_req[w_idx];
      end
`endif
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = '0;
      w_grant_nxt = r_grant;
      w_wr_nxt    = r_wr;
      w_data_nxt  = r_data;
      w_first_nxt = 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      w_ptr_nxt   = r_ptr;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_LOAD;
               w_grant_nxt = w_win;
               w_data_nxt  = bus.i_data[int'(w_win)*WIDTH +: WIDTH];
               w_wr_nxt    = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            // uart_tx takes the byte on this edge; holding otherwise covers a frame still in flight
            if (r_stb && !bus.i_tx_busy) begin
               w_state_nxt = S_SEND;
               w_wr_nxt    = 1'b0;
               w_ack_nxt   = NREQ'(1) << r_grant;
               w_first_nxt = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
               w_ptr_nxt   = (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + GW'(1);
`endif
            end else begin
               w_state_nxt = S_LOAD;
            end
         end
         S_SEND: begin
            if (!r_first && !bus.i_tx_busy) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SEND;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_wr_nxt    = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_ack   <= '0;
         r_grant <= '0;
         r_wr    <= 1'b0;
         r_data  <= '0;
         r_first <= 1'b0;
         r_busy  <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
         r_ptr   <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_ack_nxt;
         r_grant <= w_grant_nxt;
         r_wr    <= w_wr_nxt;
         r_data  <= w_data_nxt;
         r_first <= w_first_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
`ifndef UART_ARB_FIXED_PRIO_EN
         r_ptr   <= w_ptr_nxt;
`endif
      end
   end

   assign bus.o_ack     = r_ack;
   assign bus.o_grant   = r_grant;
   assign bus.o_busy    = r_busy;
   assign bus.o_tx_stb  = r_stb;
   assign bus.o_tx_wr   = r_wr;
   assign bus.o_tx_data = r_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx; second instance at CLKS_PER_BAUD=1.
module tb_uart_tx_arbiter;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int CPB   = 16;

   logic clk;
   logic rst;
   logic force_busy;

   uart_tx_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();
   uart_tx_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus1 ();

   uart_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CLKS_PER_BAUD(CPB)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   uart_tx_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CLKS_PER_BAUD(1)) dut1 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural uart_tx: start, LSB-first data, stop; records each bit put on the line
   logic             m_busy = 1'b0;
   logic [WIDTH:0]   m_sh   = '0;
   int               m_left = 0;
   int               m_bitno = 0;
   logic             m_bits[$];

   assign bus.i_tx_busy = m_busy | force_busy;

   always @(posedge clk) begin
      if (!m_busy) begin
         if (bus.o_tx_stb && bus.o_tx_wr && !force_busy) begin
            m_busy  <= 1'b1;
            m_sh    <= {1'b1, bus.o_tx_data};
            m_left  <= WIDTH + 1;
            m_bitno <= 0;
            m_bits.push_back(1'b0);
         end
      end else if (bus.o_tx_stb) begin
         if (m_left > 0) begin
            m_bits.push_back(m_sh[0]);
            m_sh    <= m_sh >> 1;
            m_left  <= m_left - 1;
            m_bitno <= m_bitno + 1;
         end else begin
            m_busy <= 1'b0;
         end
      end
   end

   // Scoreboard: expected {grant, byte} per frame, checked at the latch edge; ack checked the cycle after
   logic [15:0] exp_q[$];
   logic [15:0] e;
   logic        ack_due = 1'b0;
   logic [31:0] exp_ack = '0;

   always @(negedge clk) begin
      if (rst) begin
         ack_due = 1'b0;
      end else begin
         if (ack_due || bus.o_ack != '0)
            chk("ack", 32'(bus.o_ack), ack_due ? exp_ack : 32'd0);
         ack_due = 1'b0;
         if (bus.o_busy && bus.o_tx_stb && bus.o_tx_wr && !bus.i_tx_busy) begin
            if (exp_q.size() == 0) begin
               chk("frame_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("grant", 32'(bus.o_grant), 32'(e[15:8]));
               chk("tx_data", 32'(bus.o_tx_data), 32'(e[7:0]));
               exp_ack = 32'd1 << e[15:8];
               ack_due = 1'b1;
            end
         end
      end
   end

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((m_busy || bus.o_busy || exp_q.size() != 0) && k < 3000) begin
         tick();
         k++;
      end
      chk({tag, "_idle"}, 32'(!(m_busy || bus.o_busy || exp_q.size() != 0)), 32'd1);
   endtask

   task automatic wait_ack(input string tag, input int r);
      int k = 0;
      while (!bus.o_ack[r] && k < 500) begin
         tick();
         k++;
      end
      chk({tag, "_ack_seen"}, 32'(bus.o_ack[r]), 32'd1);
   endtask

   task automatic do_reset();
      wait_idle("pre_reset");
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [7:0] b);
      logic [9:0] exp_bits;
      exp_bits = {1'b1, b, 1'b0};
      chk($sformatf("%s_len", tag), 32'(m_bits.size()), 32'd10);
      for (int i = 0; i < 10 && i < m_bits.size(); i++)
         chk($sformatf("%s_bit%0d", tag, i), 32'(m_bits[i]), 32'(exp_bits[i]));
   endtask

   initial begin
      int n;
      int lows;
      logic seen;
      logic wr_low;
      logic ack_seen;

      rst = 1'b1;
      force_busy = 1'b0;
      bus.i_req = '0;
      bus.i_data = '0;
      bus1.i_req = '0;
      bus1.i_data = '0;
      bus1.i_tx_busy = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_ack", 32'(bus.o_ack), 32'd0);
      chk("rst_grant", 32'(bus.o_grant), 32'd0);
      chk("rst_wr", 32'(bus.o_tx_wr), 32'd0);
      chk("rst_data", 32'(bus.o_tx_data), 32'd0);
      chk("rst_stb", 32'(bus.o_tx_stb), 32'd0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      rst = 1'b0;
      n = 0;
      seen = 1'b0;
      for (int k = 1; k <= CPB + 2 && !seen; k++) begin
         tick();
         if (bus.o_tx_stb) begin
            seen = 1'b1;
            n = k;
         end
      end
      chk("stb_first", 32'(n), 32'(CPB));
      n = 0;
      seen = 1'b0;
      for (int k = 1; k <= CPB + 2 && !seen; k++) begin
         tick();
         if (bus.o_tx_stb) begin
            seen = 1'b1;
            n = k;
         end
      end
      chk("stb_period", 32'(n), 32'(CPB));

      // Single request
      m_bits.delete();
      exp_q.push_back({8'd0, 8'hA5});
      bus.i_data[7:0] = 8'hA5;
      bus.i_req = 4'b0001;
      tick();
      chk("s2_wr", 32'(bus.o_tx_wr), 32'd1);
      chk("s2_data", 32'(bus.o_tx_data), 32'hA5);
      chk("s2_busy", 32'(bus.o_busy), 32'd1);
      wait_ack("s2", 0);
      bus.i_req = 4'b0000;
      wait_idle("s2");
      check_frame("s2_line", 8'hA5);

      // Round-robin with held requests
      do_reset();
      for (int k = 0; k < NREQ; k++) bus.i_data[k*WIDTH +: WIDTH] = 8'h30 + 8'(k);
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 6; k++) exp_q.push_back({8'd0, 8'h30});
`else
      exp_q.push_back({8'd0, 8'h30});
      exp_q.push_back({8'd1, 8'h31});
      exp_q.push_back({8'd3, 8'h33});
      exp_q.push_back({8'd0, 8'h30});
      exp_q.push_back({8'd1, 8'h31});
      exp_q.push_back({8'd3, 8'h33});
`endif
      bus.i_req = 4'b1011;
      n = 0;
      for (int k = 0; k < 3000 && n < 6; k++) begin
         tick();
         if (bus.o_ack != '0) n++;
      end
      bus.i_req = 4'b0000;
      chk("s3_acks", 32'(n), 32'd6);
      wait_idle("s3");

      // uart_tx busy while loaded
      do_reset();
      force_busy = 1'b1;
      bus.i_data[7:0] = 8'h3C;
      bus.i_req = 4'b0001;
      exp_q.push_back({8'd0, 8'h3C});
      tick();
      wr_low = 1'b0;
      ack_seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (!bus.o_tx_wr) wr_low = 1'b1;
         if (bus.o_ack != '0) ack_seen = 1'b1;
      end
      chk("s4_wr_held", 32'(wr_low), 32'd0);
      chk("s4_no_ack", 32'(ack_seen), 32'd0);
      force_busy = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < CPB + 2 && !seen; k++) begin
         if (bus.o_tx_stb) seen = 1'b1;
         else tick();
      end
      chk("s4_stb_seen", 32'(seen), 32'd1);
      chk("s4_wr_at_stb", 32'(bus.o_tx_wr), 32'd1);
      tick();
      chk("s4_ack_next", 32'(bus.o_ack), 32'h1);
      bus.i_req = 4'b0000;
      wait_idle("s4");

      // Requester drops its request right after being picked
      do_reset();
      bus.i_data[23:16] = 8'h5A;
      bus.i_req = 4'b0100;
      exp_q.push_back({8'd2, 8'h5A});
      tick();
      chk("s5_loaded", 32'(bus.o_busy), 32'd1);
      bus.i_req = 4'b0000;
      bus.i_data[23:16] = 8'hFF;
      wait_ack("s5", 2);
      wait_idle("s5");

      // Reset during data bit 3, then a clean frame after uart_tx finishes
      do_reset();
      bus.i_data[7:0] = 8'h96;
      bus.i_req = 4'b0001;
      exp_q.push_back({8'd0, 8'h96});
      wait_ack("s6a", 0);
      bus.i_req = 4'b0000;
      n = 0;
      while (m_bitno != 4 && n < 500) begin
         tick();
         n++;
      end
      chk("s6_bit3_reached", 32'(m_bitno), 32'd4);
      rst = 1'b1;
      tick();
      chk("s6_busy", 32'(bus.o_busy), 32'd0);
      chk("s6_wr", 32'(bus.o_tx_wr), 32'd0);
      chk("s6_grant", 32'(bus.o_grant), 32'd0);
      rst = 1'b0;
      bus.i_data[15:8] = 8'h69;
      bus.i_req = 4'b0010;
      exp_q.push_back({8'd1, 8'h69});
      n = 0;
      while (m_busy && n < 500) begin
         tick();
         n++;
      end
      chk("s6_uart_done", 32'(m_busy), 32'd0);
      chk("s6_wr_waiting", 32'(bus.o_tx_wr), 32'd1);
      m_bits.delete();
      wait_ack("s6b", 1);
      bus.i_req = 4'b0000;
      wait_idle("s6");
      check_frame("s6_line", 8'h69);

      // CLKS_PER_BAUD = 1 instance
      lows = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (!bus1.o_tx_stb) lows++;
      end
      chk("c1_stb_const", 32'(lows), 32'd0);
      bus1.i_data[7:0] = 8'hA5;
      bus1.i_req = 4'b0001;
      tick();
      chk("c1_wr", 32'(bus1.o_tx_wr), 32'd1);
      chk("c1_data", 32'(bus1.o_tx_data), 32'hA5);
      tick();
      chk("c1_ack", 32'(bus1.o_ack), 32'h1);
      chk("c1_wr_off", 32'(bus1.o_tx_wr), 32'd0);
      bus1.i_req = 4'b0000;
      bus1.i_tx_busy = 1'b1;
      repeat (10) tick();
      chk("c1_sending", 32'(bus1.o_busy), 32'd1);
      chk("c1_ack_once", 32'(bus1.o_ack), 32'd0);
      bus1.i_tx_busy = 1'b0;
      tick();
      chk("c1_idle", 32'(bus1.o_busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
